// File: rtl/bfm_ahbslave_wait.sv
// AHB-Lite slave memory model with programmable read/write wait states, external stall,
// byte-lane writes, a two-cycle ERROR response window and transfer/error counters.
module bfm_ahbslave_wait #(
  parameter int                AWIDTH   = 10,
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 256,
  parameter int                RD_WAIT  = 0,
  parameter int                WR_WAIT  = 0,
  parameter int                ERR_EN   = 0,
  parameter logic [AWIDTH-1:0] ERR_BASE = '0,
  parameter logic [AWIDTH-1:0] ERR_MASK = '0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic              HREADYIN,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DWIDTH-1:0] HRDATA,
  input  logic              STALL,
  output logic [15:0]       XFER_CNT,
  output logic [7:0]        ERR_CNT
);

  localparam int NB = DWIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_W = 4'(RD_WAIT);
  localparam logic [3:0] WR_W = 4'(WR_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t              state;
  logic [AWIDTH-1:0]   addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic [3:0]          cnt;
  logic                accept;
  logic                err_hit;
  logic [IW-1:0]       idx;
  logic [NB-1:0]       lanes;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic                unused;

  function automatic logic [AWIDTH-1:0] size_mask(input logic [2:0] size);
    logic [AWIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < AWIDTH; i++) m[i] = (i < int'(size));
    return m;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [AWIDTH-1:0] addr);
    logic [NB-1:0] m;
    int start;
    int n;
    start = int'(addr) % NB;
    n = 32'd1 << size;
    for (int i = 0; i < NB; i++) m[i] = (i >= start) && (i < start + n);
    return m;
  endfunction

  assign unused  = ^{HBURST, HTRANS[0]};
  assign accept  = HSEL & HREADYIN & HTRANS[1];
  assign err_hit = ((ERR_EN != 0) && ((HADDR & ERR_MASK) == ERR_BASE)) ||
                   (HSIZE > 3'(LB)) || ((HADDR & size_mask(HSIZE)) != '0);
  assign idx     = IW'((32'(addr_q) >> LB) % 32'(DEPTH));
  assign lanes   = lane_mask(size_q, addr_q);

  // Ready is combinational so a DATA phase can finish in the same cycle STALL drops.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_IDLE: begin HREADYOUT = 1'b1; HRESP = 1'b0; end
      S_DATA: begin HREADYOUT = (cnt == 4'd0) && !STALL; HRESP = 1'b0; end
      S_ERR1: begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      S_ERR2: begin HREADYOUT = 1'b1; HRESP = 1'b1; end
      default: begin HREADYOUT = 1'b1; HRESP = 1'b0; end
    endcase
  end

  assign HRDATA = (state == S_DATA && !write_q && HREADYOUT) ? mem[idx] : '0;

  // Every ready edge is a decision point: start the next transfer or fall back to IDLE.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      cnt      <= 4'd0;
      XFER_CNT <= 16'd0;
      ERR_CNT  <= 8'd0;
    end else begin
      if (HREADYOUT) begin
        if (accept) begin
          addr_q  <= HADDR;
          write_q <= HWRITE;
          size_q  <= HSIZE;
          cnt     <= err_hit ? 4'd0 : (HWRITE ? WR_W : RD_W);
          state   <= err_hit ? S_ERR1 : S_DATA;
        end else begin
          state <= S_IDLE;
        end
      end else if (state == S_ERR1) begin
        state <= S_ERR2;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= state;
      end
      if (state == S_DATA && HREADYOUT) XFER_CNT <= XFER_CNT + 16'd1;
      if (state == S_ERR2 && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  // Storage is never reset; writes land only on the edge that completes the data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && write_q && HREADYOUT) begin
      for (int b = 0; b < NB; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bfm_ahbslave_wait.sv
// Self-checking bench: three slave configurations driven by directed and random transfers,
// checked against a byte-addressed reference memory and transfer-rule model.
module tb_bfm_ahbslave_wait;

  localparam int NBK  [3] = '{4, 4, 8};
  localparam int LBK  [3] = '{2, 2, 3};
  localparam int RDK  [3] = '{0, 3, 0};
  localparam int WRK  [3] = '{0, 1, 4};
  localparam int ERRK [3] = '{0, 1, 0};
  localparam int BASEK[3] = '{0, 'h300, 0};
  localparam int MASKK[3] = '{0, 'h300, 0};

  logic        clk;
  logic        hreset;
  logic [2:0]  hsel;
  logic        hwrite;
  logic [9:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic        stall_in;
  logic        rdy [3];
  logic        rsp [3];
  logic [63:0] rdat [3];
  logic [15:0] xc [3];
  logic [7:0]  ec [3];
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [63:0] rd2;

  int          vectors = 0;
  int          miscompares = 0;
  bit [7:0]    mref [int];
  int          xc_m [3];
  int          ec_m [3];

  assign rdat[0] = {32'h0, rd0};
  assign rdat[1] = {32'h0, rd1};
  assign rdat[2] = rd2;

  bfm_ahbslave_wait #(.DWIDTH(32)) u0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HWRITE(hwrite), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata[31:0]),
    .HREADYIN(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(rsp[0]), .HRDATA(rd0),
    .STALL(stall_in), .XFER_CNT(xc[0]), .ERR_CNT(ec[0]));

  bfm_ahbslave_wait #(.DWIDTH(32), .RD_WAIT(3), .WR_WAIT(1), .ERR_EN(1),
                      .ERR_BASE(10'h300), .ERR_MASK(10'h300)) u1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HWRITE(hwrite), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata[31:0]),
    .HREADYIN(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(rsp[1]), .HRDATA(rd1),
    .STALL(stall_in), .XFER_CNT(xc[1]), .ERR_CNT(ec[1]));

  bfm_ahbslave_wait #(.DWIDTH(64), .RD_WAIT(0), .WR_WAIT(4)) u2 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[2]), .HWRITE(hwrite), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADYIN(rdy[2]), .HREADYOUT(rdy[2]), .HRESP(rsp[2]), .HRDATA(rd2),
    .STALL(stall_in), .XFER_CNT(xc[2]), .ERR_CNT(ec[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input int k, input int a, input int sz);
    if (sz > LBK[k]) return 1'b1;
    if (a % (1 << sz) != 0) return 1'b1;
    if (ERRK[k] != 0 && ((a & MASKK[k]) == BASEK[k])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int key_base(input int k, input int a);
    return k * 8192 + ((a / NBK[k]) % 256) * NBK[k];
  endfunction

  function automatic logic [63:0] mword(input int k, input int a);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < NBK[k]; b++) v[8*b +: 8] = mref[key_base(k, a) + b];
    return v;
  endfunction

  task automatic mwrite(input int k, input int a, input int sz, input logic [63:0] wd);
    int off;
    off = a % NBK[k];
    for (int b = off; b < off + (1 << sz); b++) mref[key_base(k, a) + b] = wd[8*b +: 8];
  endtask

  task automatic chk_counters(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "/xfer_cnt"}, 64'(xc[k]), 64'(xc_m[k] % 65536));
      chk({tag, "/err_cnt"}, 64'(ec[k]), 64'(ec_m[k] > 255 ? 255 : ec_m[k]));
    end
  endtask

  // One non-pipelined transfer; stall adds extra STALL cycles after the wait count.
  task automatic xfer(input int k, input bit wr, input int a, input int sz,
                      input logic [63:0] wd, input int stall, input string tag);
    bit er;
    int w;
    int lows;
    bit done;
    logic rsp_lo;
    logic rp;
    logic [63:0] rd;
    er = exp_err(k, a, sz);
    w  = er ? 1 : (wr ? WRK[k] : RDK[k]);
    @(negedge clk);
    hsel = 3'b000; hsel[k] = 1'b1; htrans = 2'b10; hwrite = wr;
    haddr = 10'(a); hsize = 3'(sz); hburst = 3'(k);
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; hwdata = wd;
    lows = 0; done = 1'b0; rsp_lo = 1'b0; rp = 1'b0; rd = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      stall_in = !er && (stall > 0) && (lows < w + stall);
      #1;
      if (rdy[k]) begin done = 1'b1; rd = rdat[k]; rp = rsp[k]; end
      else begin lows++; rsp_lo = rsp[k]; end
    end
    stall_in = 1'b0;
    chk({tag, "/completed"}, 64'(done), 64'd1);
    if (er) begin
      ec_m[k]++;
      chk({tag, "/err_low_cycles"}, 64'(lows), 64'd1);
      chk({tag, "/err_resp_1st"}, 64'(rsp_lo), 64'd1);
      chk({tag, "/err_resp_2nd"}, 64'(rp), 64'd1);
      chk({tag, "/err_rdata"}, rd, 64'd0);
    end else begin
      xc_m[k]++;
      chk({tag, "/low_cycles"}, 64'(lows), 64'(w + stall));
      chk({tag, "/resp"}, 64'(rp), 64'd0);
      if (wr) begin
        mwrite(k, a, sz, wd);
        chk({tag, "/wr_rdata"}, rd, 64'd0);
      end else begin
        chk({tag, "/rdata"}, rd, mword(k, a));
      end
    end
  endtask

  initial begin
    int lows;
    bit done;
    int pool [3][8];
    hreset = 1'b1; hsel = 3'b000; hwrite = 1'b0; haddr = 10'd0; htrans = 2'b00;
    hsize = 3'd0; hburst = 3'd0; hwdata = 64'd0; stall_in = 1'b0;
    for (int k = 0; k < 3; k++) begin xc_m[k] = 0; ec_m[k] = 0; end
    repeat (3) @(negedge clk);
    hreset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset/hreadyout", 64'(rdy[k]), 64'd1);
      chk("reset/hresp", 64'(rsp[k]), 64'd0);
      chk("reset/hrdata", rdat[k], 64'd0);
    end
    chk_counters("reset");

    // zero-wait write then read
    xfer(0, 1'b1, 'h010, 2, 64'hDEADBEEF, 0, "t1/wr");
    xfer(0, 1'b0, 'h010, 2, 64'h0, 0, "t1/rd");
    @(negedge clk);
    chk("t1/xfer_cnt", 64'(xc[0]), 64'd2);

    // byte-lane write inside an existing word
    xfer(0, 1'b1, 'h020, 2, 64'h11223344, 0, "t2/init");
    xfer(0, 1'b1, 'h021, 0, 64'h5555AA55, 0, "t2/byte");
    xfer(0, 1'b0, 'h020, 2, 64'h0, 0, "t2/rd");
    chk("t2/model_word", mword(0, 'h020), 64'h1122AA44);

    // wait states and external stall
    xfer(1, 1'b1, 'h050, 2, 64'hCAFEF00D, 0, "t3/wr");
    xfer(1, 1'b0, 'h050, 2, 64'h0, 0, "t3/rd");
    xfer(1, 1'b0, 'h050, 2, 64'h0, 2, "t3/rd_stall");

    // error window
    xfer(1, 1'b1, 'h304, 2, 64'h12345678, 0, "t4/win");
    @(negedge clk);
    chk("t4/err_cnt", 64'(ec[1]), 64'd1);
    chk_counters("t4");

    // pipelined 64-bit write then read of the same word
    @(negedge clk);
    hsel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 10'h040; hsize = 3'd3;
    @(negedge clk);
    hwrite = 1'b0; hwdata = 64'h0123456789ABCDEF;
    lows = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rdy[2]) done = 1'b1; else lows++;
    end
    chk("t5/wr_low_cycles", 64'(lows), 64'(WRK[2]));
    mwrite(2, 'h040, 3, 64'h0123456789ABCDEF);
    xc_m[2]++;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00;
    #1;
    chk("t5/rd_ready", 64'(rdy[2]), 64'd1);
    chk("t5/rd_resp", 64'(rsp[2]), 64'd0);
    chk("t5/rd_data", rdat[2], 64'h0123456789ABCDEF);
    xc_m[2]++;
    xfer(2, 1'b0, 'h044, 3, 64'h0, 0, "t5/dword_misaligned");

    // randomized mix: full-word initialisation, then random sizes, offsets and stalls
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 8; p++) begin
        pool[k][p] = int'($urandom_range(0, 1023)) & ~(NBK[k] - 1);
        xfer(k, 1'b1, pool[k][p], LBK[k], {$urandom, $urandom}, 0, "rnd/init");
      end
      for (int n = 0; n < 30; n++) begin
        xfer(k, 1'($urandom_range(0, 1)),
             pool[k][$urandom_range(0, 7)] + int'($urandom_range(0, NBK[k] - 1)),
             int'($urandom_range(0, LBK[k] + 1)), {$urandom, $urandom},
             int'($urandom_range(0, 2)), "rnd/op");
      end
    end
    @(negedge clk);
    chk_counters("rnd");

    // reset in the second cycle of a 4-wait write
    xfer(2, 1'b1, 'h080, 3, 64'hAAAAAAAAAAAAAAAA, 0, "t6/pre");
    @(negedge clk);
    hsel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 10'h080; hsize = 3'd3;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; hwdata = 64'h5555555555555555;
    @(negedge clk);
    hreset = 1'b1;
    @(negedge clk);
    hreset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6/hreadyout", 64'(rdy[k]), 64'd1);
      chk("t6/hresp", 64'(rsp[k]), 64'd0);
      chk("t6/hrdata", rdat[k], 64'd0);
      xc_m[k] = 0; ec_m[k] = 0;
    end
    chk_counters("t6");
    xfer(2, 1'b0, 'h080, 3, 64'h0, 0, "t6/word_kept");
    chk("t6/model_word", mword(2, 'h080), 64'hAAAAAAAAAAAAAAAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
